upscale_stream_packer: RTL and testbench
========================================

Name: upscale_stream_packer

Overview:
Downstream stage of the bicubic upscaler top level. Accepts the upscaler's free-running 24-bit RGB pixel stream (valid-only, no backpressure), tags each pixel with start-of-frame and end-of-line markers from output-raster counters, and buffers the pixels in a small FIFO. The output is a valid/ready stream toward the frame writer or video output. Upstream cannot stall, so overflow is detected, counted as a sticky flag, and never corrupts framing.

Parameters:
OUT_W, 1152, output line width in pixels (3x of 384-wide input).
OUT_H, 648, output lines per frame (3x of 216).
DATA_W, 24, pixel width, {R[23:16], G[15:8], B[7:0]}.
FIFO_DEPTH, 16, FIFO entries; power of two, >= 4.

Ports:
clk  in  1  single clock; all state on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
s_pixel  in  DATA_W  pixel from upscaler (pixel_out).
s_valid  in  1  upstream valid (output_valid); no ready returned.
m_data  out  DATA_W  FIFO head pixel.
m_sof  out  1  head pixel is x=0,y=0.
m_eol  out  1  head pixel is x=OUT_W-1.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  downstream accepts head when high with m_valid.
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky; set when a pixel is dropped.
ovf_clr  in  1  synchronous clear of overflow.
frame_done  out  1  one-cycle pulse after the last pixel of a frame arrives.

Behaviour:
- Reset (rst=0, async): x=0, y=0, FIFO pointers=0, level=0, m_valid=0, m_sof=0, m_eol=0, m_data=0, overflow=0, frame_done=0.
- Raster counters advance on every s_valid cycle, whether or not the pixel is stored. Dropped pixels keep raster position in step with upstream.
- Tags use the counter values before the advance: sof = (x==0 && y==0); eol = (x==OUT_W-1).
- Counter wrap: at x==OUT_W-1, x<=0 and y<=y+1. At x==OUT_W-1 && y==OUT_H-1, x<=0 and y<=0; frame_done=1 on the next cycle only.
- Push: s_valid && !full writes {sof, eol, s_pixel} (DATA_W+2 bits) at wr_ptr. Entry is visible on m_* from the following cycle; s_valid at edge N gives m_valid=1 after edge N.
- Drop: s_valid && full discards the pixel and sets overflow the next cycle. Overflow holds until ovf_clr=1. If ovf_clr and a new drop occur together, the set wins.
- Pop: m_valid && m_ready advances rd_ptr. m_data, m_sof and m_eol come from mem[rd_ptr] and are forced to 0 when empty.
- "full" is evaluated pre-edge. A push while full is rejected even if a pop occurs in the same cycle.
- Push+pop when not full and not empty: level unchanged. Pop cannot occur when empty because m_valid=0.
- Pointers carry one extra wrap bit. full = MSBs differ and low bits are equal. Pointers wrap naturally modulo 2*FIFO_DEPTH.
- m_data must stay stable while m_valid && !m_ready.
- A mid-frame reset restarts at x=0,y=0 and flushes the FIFO. The next accepted pixel is tagged sof.

Decomposition:
- Shared package/header:
  - pixel width 24;
  - channel slice positions;
  - upscale factor 3;
  - default IMG_W/IMG_H and derived OUT_W/OUT_H, so the upscaler top and this block agree.
- One sub-module: sync_fifo (parameterised width/depth, first-word-fall-through, full/empty/level). The packer adds counters, tagging, overflow and frame_done around it.

Test Plan:
1. Use OUT_W=6, OUT_H=2, FIFO_DEPTH=4, m_ready=1. Drive 12 consecutive s_valid pixels 0x000001..0x00000C. Required response:
   - m_sof set only on 0x000001;
   - m_eol on 0x000006 and 0x00000C;
   - frame_done pulses once, the cycle after 0x00000C;
   - each pixel appears 1 cycle after input.
2. Hold m_ready=0 and push 6 pixels (0xA0..0xA5). Required response:
   - level reaches 4 and stays there;
   - 0xA4 and 0xA5 are dropped and overflow=1;
   - releasing m_ready drains exactly 0xA0..0xA3 in order.
3. After test 2, continue the stream. 0xA6 must carry m_eol=0 and the pixel at x=5 must carry m_eol=1 (framing kept across drops). Pulse ovf_clr and check overflow=0.
4. Fill the FIFO to level=3, then assert s_valid and m_ready for one cycle together. Check level stays 3 and the head advances by one entry.
5. Toggle m_ready randomly 50% over 2 frames. Required response: output sequence equals input sequence, m_data is stable while stalled, and there are no drops at input duty 1/2.
6. Assert rst=0 asynchronously at x=3 with 2 entries buffered. Required response:
   - m_valid=0 immediately;
   - the next pixel after release comes out with m_sof=1;
   - overflow=0 and level=0.

Source files
------------

// File: rtl/upscale_stream_packer_pkg.sv
// -----------------------------------------------------------------------------
// upscale_stream_packer_pkg
// Constants shared by the bicubic upscaler top level and the output packer, so
// both agree on pixel layout, upscale factor and output raster size.
// -----------------------------------------------------------------------------
package upscale_stream_packer_pkg;

    // Pixel layout {R, G, B}
    localparam int unsigned PIXEL_W = 24;
    localparam int unsigned CHAN_W  = 8;
    localparam int unsigned R_LSB   = 16;
    localparam int unsigned G_LSB   = 8;
    localparam int unsigned B_LSB   = 0;

    // Upscale geometry
    localparam int unsigned UPSCALE   = 3;
    localparam int unsigned IMG_W     = 384;
    localparam int unsigned IMG_H     = 216;
    localparam int unsigned OUT_W_DEF = IMG_W * UPSCALE;
    localparam int unsigned OUT_H_DEF = IMG_H * UPSCALE;

    localparam int unsigned FIFO_DEPTH_DEF = 16;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upscale_stream_packer_sync_fifo.sv
// -----------------------------------------------------------------------------
// upscale_stream_packer_sync_fifo
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_push, i_wdata    write request (ignored when full)
//   i_pop              read request (ignored when empty)
//   o_rdata            head entry, zero when empty
//   o_full, o_empty    occupancy flags
//   o_level            number of stored entries
// -----------------------------------------------------------------------------
module upscale_stream_packer_sync_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

    // Flags are pre-edge: a push while full is refused even if a pop happens too.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; empty masks stale contents.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/upscale_stream_packer.sv
// -----------------------------------------------------------------------------
// upscale_stream_packer
// Tags the upscaler's free-running pixel stream with start-of-frame and
// end-of-line markers from output-raster counters, buffers it in a FIFO and
// presents a valid/ready stream. Upstream cannot stall: pixels arriving while
// the FIFO is full are dropped, flagged in a sticky overflow bit, and the
// raster counters still advance so framing stays aligned with upstream.
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_s_pixel, i_s_valid    upstream pixel stream (no ready)
//   o_m_data/_sof/_eol      FIFO head pixel and its tags (zero when empty)
//   o_m_valid, i_m_ready    downstream handshake
//   o_level                 FIFO occupancy
//   o_overflow, i_ovf_clr   sticky drop flag and its synchronous clear
//   o_frame_done            one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module upscale_stream_packer
    import upscale_stream_packer_pkg::*;
#(
    parameter int unsigned OUT_W      = OUT_W_DEF,
    parameter int unsigned OUT_H      = OUT_H_DEF,
    parameter int unsigned DATA_W     = PIXEL_W,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_W-1:0]             i_s_pixel,
    input  logic                          i_s_valid,
    output logic [DATA_W-1:0]             o_m_data,
    output logic                          o_m_sof,
    output logic                          o_m_eol,
    output logic                          o_m_valid,
    input  logic                          i_m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    input  logic                          i_ovf_clr,
    output logic                          o_frame_done
);

    localparam int unsigned XW = cnt_width(OUT_W);
    localparam int unsigned YW = cnt_width(OUT_H);
    localparam int unsigned EW = DATA_W + 2;
    localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_overflow;
    logic          r_frame_done;

    logic          w_x_last;
    logic          w_y_last;
    logic          w_sof;
    logic          w_eol;
    logic          w_full;
    logic          w_empty;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);
    assign w_sof    = (r_x == '0) && (r_y == '0);
    assign w_eol    = w_x_last;
    assign w_wdata  = {w_sof, w_eol, i_s_pixel};

    upscale_stream_packer_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_s_valid),
        .i_wdata (w_wdata),
        .i_pop   (i_m_ready),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    assign o_m_valid    = !w_empty;
    assign o_m_data     = w_rdata[DATA_W-1:0];
    assign o_m_eol      = w_rdata[DATA_W];
    assign o_m_sof      = w_rdata[DATA_W+1];
    assign o_overflow   = r_overflow;
    assign o_frame_done = r_frame_done;

    // Raster position follows every upstream pixel, stored or dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= i_s_valid && w_x_last && w_y_last;
            if (i_s_valid) begin
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_s_valid && w_full) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_upscale_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_upscale_stream_packer
// Directed bench for upscale_stream_packer on a 6x2 raster with a 4-entry FIFO.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_upscale_stream_packer;

    localparam int unsigned OW    = 6;
    localparam int unsigned OH    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 24;

    typedef struct {
        logic [DW-1:0] pix;
        logic          sof;
        logic          eol;
        logic          fd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_pixel = '0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;
    logic          m_valid;
    logic [2:0]    level;
    logic          overflow;
    logic          frame_done;

    int            n_pass = 0;
    int            n_total = 0;
    int            mx = 0;
    int            my = 0;
    logic [25:0]   sb[$];
    logic          stalled = 1'b0;
    logic [DW-1:0] held = '0;
    vec_t          t1[12];

    always #5 clk = ~clk;

    upscale_stream_packer #(
        .OUT_W      (OW),
        .OUT_H      (OH),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_s_pixel    (s_pixel),
        .i_s_valid    (s_valid),
        .o_m_data     (m_data),
        .o_m_sof      (m_sof),
        .o_m_eol      (m_eol),
        .o_m_valid    (m_valid),
        .i_m_ready    (m_ready),
        .o_level      (level),
        .o_overflow   (overflow),
        .i_ovf_clr    (ovf_clr),
        .o_frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock: apply inputs, keep a raster model for expected tags, record
    // every upstream pixel, then return at the next falling edge.
    task automatic drive(input logic v, input logic [DW-1:0] p, input logic r, input logic clr);
        logic t_sof;
        logic t_eol;
        s_valid = v;
        s_pixel = p;
        m_ready = r;
        ovf_clr = clr;
        if (v) begin
            t_sof = (mx == 0) && (my == 0);
            t_eol = (mx == OW - 1);
            sb.push_back({t_sof, t_eol, p});
            if (mx == OW - 1) begin
                mx = 0;
                my = (my == OH - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        ovf_clr = 1'b0;
    endtask

    // Scoreboarded cycle: compares the head against the model when it is
    // consumed, and checks it held still while stalled.
    task automatic cyc(input logic v, input logic [DW-1:0] p, input logic r);
        logic [25:0] e;
        if (stalled) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, held);
        end
        if (m_valid && r) begin
            chk("sb_has_entry", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("t5_data", m_data, e[23:0]);
                chk("t5_eol", m_eol, e[24]);
                chk("t5_sof", m_sof, e[25]);
            end
        end
        stalled = m_valid && !r;
        held    = m_data;
        drive(v, p, r, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t1[0]  = '{24'h000001, 1'b1, 1'b0, 1'b0};
        t1[1]  = '{24'h000002, 1'b0, 1'b0, 1'b0};
        t1[2]  = '{24'h000003, 1'b0, 1'b0, 1'b0};
        t1[3]  = '{24'h000004, 1'b0, 1'b0, 1'b0};
        t1[4]  = '{24'h000005, 1'b0, 1'b0, 1'b0};
        t1[5]  = '{24'h000006, 1'b0, 1'b1, 1'b0};
        t1[6]  = '{24'h000007, 1'b0, 1'b0, 1'b0};
        t1[7]  = '{24'h000008, 1'b0, 1'b0, 1'b0};
        t1[8]  = '{24'h000009, 1'b0, 1'b0, 1'b0};
        t1[9]  = '{24'h00000A, 1'b0, 1'b0, 1'b0};
        t1[10] = '{24'h00000B, 1'b0, 1'b0, 1'b0};
        t1[11] = '{24'h00000C, 1'b0, 1'b1, 1'b1};

        // Reset state
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_sof", m_sof, 0);
        chk("rst_m_eol", m_eol, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: one full frame, always ready
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, t1[i].pix, 1'b1, 1'b0);
            chk("t1_valid", m_valid, 1);
            chk("t1_data", m_data, t1[i].pix);
            chk("t1_sof", m_sof, t1[i].sof);
            chk("t1_eol", m_eol, t1[i].eol);
            chk("t1_frame_done", frame_done, t1[i].fd);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("t1_fd_single", frame_done, 0);
        chk("t1_empty", m_valid, 0);

        // Test 2: stalled output, overfill by two
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 24'hA0 + 24'(i), 1'b0, 1'b0);
            chk("t2_level", level, (i < 4) ? i + 1 : 4);
            chk("t2_overflow", overflow, (i >= 4) ? 1 : 0);
            chk("t2_head", m_data, 24'hA0);
        end
        chk("t2_head_sof", m_sof, 1);
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain_data", m_data, 24'hA0 + 24'(k));
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        chk("t2_drained", m_valid, 0);
        chk("t2_level0", level, 0);
        chk("t2_ovf_sticky", overflow, 1);

        // Test 3: framing survives the drops, then clear overflow
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 24'hA6 + 24'(k), 1'b1, 1'b0);
            chk("t3_data", m_data, 24'hA6 + 24'(k));
            chk("t3_eol", m_eol, (k == 5) ? 1 : 0);
            chk("t3_sof", m_sof, 0);
            chk("t3_frame_done", frame_done, (k == 5) ? 1 : 0);
        end
        chk("t3_ovf_before_clr", overflow, 1);
        drive(1'b0, '0, 1'b1, 1'b1);
        chk("t3_ovf_cleared", overflow, 0);
        chk("t3_empty", m_valid, 0);

        // Test 4: simultaneous push and pop at level 3
        drive(1'b1, 24'hB0, 1'b0, 1'b0);
        drive(1'b1, 24'hB1, 1'b0, 1'b0);
        drive(1'b1, 24'hB2, 1'b0, 1'b0);
        chk("t4_level3", level, 3);
        chk("t4_head_b0", m_data, 24'hB0);
        chk("t4_head_b0_sof", m_sof, 1);
        drive(1'b1, 24'hB3, 1'b1, 1'b0);
        chk("t4_level_kept", level, 3);
        chk("t4_head_b1", m_data, 24'hB1);
        for (int k = 1; k < 4; k++) begin
            chk("t4_drain", m_data, 24'hB0 + 24'(k));
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        chk("t4_empty", m_valid, 0);

        // Test 5: random 50% ready over two frames, input every other cycle
        sb.delete();
        stalled = 1'b0;
        for (int k = 0; k < 24; k++) begin
            automatic int r = $urandom_range(0, 1);
            cyc(1'b1, 24'hD000 + 24'(k), (r == 0));
            cyc(1'b0, '0, (r == 1));
        end
        for (int i = 0; i < 8 && (sb.size() != 0 || m_valid); i++) begin
            cyc(1'b0, '0, 1'b1);
        end
        chk("t5_all_out", sb.size(), 0);
        chk("t5_empty", m_valid, 0);
        chk("t5_no_drop", overflow, 0);

        // Test 6: asynchronous reset mid-line with two entries buffered
        for (int i = 0; i < 2 * OW && mx != 1; i++) begin
            drive(1'b1, 24'hE0 + 24'(i), 1'b1, 1'b0);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, 24'hF0, 1'b0, 1'b0);
        drive(1'b1, 24'hF1, 1'b0, 1'b0);
        chk("t6_x_at_3", mx, 3);
        chk("t6_level2", level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_level", level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mx = 0;
        my = 0;
        @(negedge clk);
        chk("t6_level_after", level, 0);
        chk("t6_ovf_after", overflow, 0);
        drive(1'b1, 24'hC0, 1'b1, 1'b0);
        chk("t6_valid", m_valid, 1);
        chk("t6_data", m_data, 24'hC0);
        chk("t6_sof", m_sof, 1);
        chk("t6_eol", m_eol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
